// File: rtl/mem_llsc_unit_pkg.sv
// Shared LL/SC definitions: MEM-stage FSM encoding, flush-cause value and SC result codes.
package mem_llsc_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } llsc_state_e;

    localparam logic FLUSH_CAUSE_EXC = 1'b1;
    localparam logic SC_RES_OK       = 1'b1;
    localparam logic SC_RES_FAIL     = 1'b0;

endpackage

// File: rtl/llsc_link_match.sv
// Link register holding the word address of the last LL, plus the SC address comparator.
// Only built with LLSC_ADDR_MATCH_EN defined.
`ifdef LLSC_ADDR_MATCH_EN
module llsc_link_match #(
    parameter int TAG_W = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic [TAG_W-1:0] set_tag_i,
    input  logic [TAG_W-1:0] cmp_tag_i,
    output logic             match_o
);

    logic [TAG_W-1:0] link_addr_q;
    logic             link_vld_q;

    // An exception clear wins over a same-cycle set; the FSM never asserts both.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_addr_q <= '0;
            link_vld_q  <= 1'b0;
        end else if (clr_i) begin
            link_vld_q  <= 1'b0;
        end else if (set_i) begin
            link_addr_q <= set_tag_i;
            link_vld_q  <= 1'b1;
        end
    end

    assign match_o = link_vld_q && (link_addr_q == cmp_tag_i);

endmodule
`endif

// File: rtl/mem_llsc_unit.sv
// MEM-stage LL/SC executor: drives the data bus, decides SC success, emits the LLbit write for WB.
// Optional LLSC_ADDR_MATCH_EN adds a link-address check to SC success.
module mem_llsc_unit
    import mem_llsc_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              flush_cause,
    input  logic              op_valid,
    input  logic              op_is_sc,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic              llbit_reg_i,
    input  logic              wb_llbit_we,
    input  logic              wb_llbit_val,
    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              llbit_we_o,
    output logic              llbit_val_o,
    output logic              exc_adel,
    output logic              exc_ades
);

    llsc_state_e       state_q, state_d;
    logic [ADDR_W-1:2] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              is_sc_q, is_sc_d;
    logic              llwe_q, llwe_d;

    logic              eff_llbit;
    logic              sc_allowed;
    logic              misaligned;
    logic              idle_take;
    logic              link_set;
    logic [DATA_W-1:0] bus_result;

    // The WB-stage write is newer than the committed register, so it takes priority.
    assign eff_llbit  = wb_llbit_we ? wb_llbit_val : llbit_reg_i;
    assign misaligned = (op_addr[1:0] != 2'b00);
    assign idle_take  = (state_q == ST_IDLE) && op_valid && !flush;
    assign bus_result = is_sc_q ? DATA_W'(SC_RES_OK) : data_rdata;

`ifdef LLSC_ADDR_MATCH_EN
    logic link_match;

    llsc_link_match #(
        .TAG_W (ADDR_W - 2)
    ) u_link (
        .clk       (clk),
        .rst       (rst),
        .set_i     (link_set),
        .clr_i     (flush && (flush_cause == FLUSH_CAUSE_EXC)),
        .set_tag_i (addr_q),
        .cmp_tag_i (op_addr[ADDR_W-1:2]),
        .match_o   (link_match)
    );

    assign sc_allowed = eff_llbit && link_match;
`else
    logic unused_flush_cause;
    logic unused_link_set;

    assign unused_flush_cause = flush_cause;
    assign unused_link_set    = link_set;
    assign sc_allowed         = eff_llbit;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        is_sc_d  = is_sc_q;
        llwe_d   = llwe_q;
        link_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (idle_take && !misaligned) begin
                    addr_d  = op_addr[ADDR_W-1:2];
                    wdata_d = op_wdata;
                    is_sc_d = op_is_sc;
                    if (op_is_sc && !sc_allowed) begin
                        result_d = DATA_W'(SC_RES_FAIL);
                        llwe_d   = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        llwe_d   = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            // data_req is masked by flush, so a flushed request can never be accepted.
            ST_REQ: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (data_addr_ok) begin
                    if (data_data_ok) begin
                        result_d = bus_result;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    result_d = bus_result;
                    state_d  = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_d  = ST_DRAIN;
                end
            end
            ST_DONE: begin
                link_set = !flush && !is_sc_q;
                state_d  = ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            is_sc_q  <= 1'b0;
            llwe_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            is_sc_q  <= is_sc_d;
            llwe_q   <= llwe_d;
        end
    end

    assign data_req    = (state_q == ST_REQ) && !flush;
    assign data_wr     = data_req && is_sc_q;
    assign data_addr   = {addr_q, 2'b00};
    assign data_wdata  = wdata_q;
    assign stall_req   = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                         (((state_q == ST_DONE) || (state_q == ST_DRAIN)) && op_valid);
    assign done        = (state_q == ST_DONE) && !flush;
    assign result      = result_q;
    assign llbit_we_o  = done && llwe_q;
    assign llbit_val_o = done && llwe_q && !is_sc_q;
    assign exc_adel    = idle_take && misaligned && !op_is_sc;
    assign exc_ades    = idle_take && misaligned && op_is_sc;

endmodule

// File: tb/tb_mem_llsc_unit.sv
// Directed cycle-vector bench for mem_llsc_unit: per-cycle inputs with hand-computed outputs.
module tb_mem_llsc_unit;

    localparam int C_REQ  = 128;
    localparam int C_WR   = 64;
    localparam int C_STL  = 32;
    localparam int C_DN   = 16;
    localparam int C_WE   = 8;
    localparam int C_VAL  = 4;
    localparam int C_ADEL = 2;
    localparam int C_ADES = 1;

    typedef struct {
        logic        v, sc, llr, wwe, wval, aok, dok, fl, fc;
        logic [31:0] addr, wd, rd;
        logic [7:0]  ectl;
        logic [31:0] eres, eaddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, flush_cause = 1'b0;
    logic        op_valid = 1'b0, op_is_sc = 1'b0;
    logic [31:0] op_addr = '0, op_wdata = '0;
    logic        llbit_reg_i = 1'b0, wb_llbit_we = 1'b0, wb_llbit_val = 1'b0;
    logic        data_req, data_wr;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        stall_req, done;
    logic [31:0] result;
    logic        llbit_we_o, llbit_val_o, exc_adel, exc_ades;

    int n_chk  = 0;
    int n_pass = 0;
    vec_t tbl[$];

    mem_llsc_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_cause(flush_cause),
        .op_valid(op_valid), .op_is_sc(op_is_sc), .op_addr(op_addr), .op_wdata(op_wdata),
        .llbit_reg_i(llbit_reg_i), .wb_llbit_we(wb_llbit_we), .wb_llbit_val(wb_llbit_val),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stall_req(stall_req), .done(done), .result(result),
        .llbit_we_o(llbit_we_o), .llbit_val_o(llbit_val_o),
        .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int v, input int sc, input logic [31:0] addr,
                                input logic [31:0] wd, input int llr, input int wwe, input int wval,
                                input int aok, input int dok, input logic [31:0] rd,
                                input int fl, input int fc, input int ectl,
                                input logic [31:0] eres, input logic [31:0] eaddr);
        vec_t t;
        t.v = v[0]; t.sc = sc[0]; t.addr = addr; t.wd = wd;
        t.llr = llr[0]; t.wwe = wwe[0]; t.wval = wval[0];
        t.aok = aok[0]; t.dok = dok[0]; t.rd = rd; t.fl = fl[0]; t.fc = fc[0];
        t.ectl = ectl[7:0]; t.eres = eres; t.eaddr = eaddr;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run_vec(input vec_t t, input string nm);
        logic [7:0] ctl;
        @(negedge clk);
        op_valid = t.v; op_is_sc = t.sc; op_addr = t.addr; op_wdata = t.wd;
        llbit_reg_i = t.llr; wb_llbit_we = t.wwe; wb_llbit_val = t.wval;
        data_addr_ok = t.aok; data_data_ok = t.dok; data_rdata = t.rd;
        flush = t.fl; flush_cause = t.fc;
        #1;
        ctl = {data_req, data_wr, stall_req, done, llbit_we_o, llbit_val_o, exc_adel, exc_ades};
        check({nm, "/ctl"}, {24'h0, ctl}, {24'h0, t.ectl});
        if ((t.ectl & 8'h10) != 0) check({nm, "/result"}, result, t.eres);
        if ((t.ectl & 8'h80) != 0) check({nm, "/addr"}, data_addr, t.eaddr);
        if ((t.ectl & 8'h40) != 0) check({nm, "/wdata"}, data_wdata, t.wd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // LL @0x100: accept, req, data_ok, done
        tbl.push_back(mk(1,0,32'h100,0,0,0,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,32'h100,0,0,0,0,1,0,0,0,0, C_REQ|C_STL,0,32'h100));
        tbl.push_back(mk(1,0,32'h100,0,0,0,0,0,1,32'hDEADBEEF,0,0, C_STL,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, C_DN|C_WE|C_VAL,32'hDEADBEEF,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
        // SC @0x100 with LLbit=1, addr_ok and data_ok together
        tbl.push_back(mk(1,1,32'h100,32'h12345678,1,0,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,32'h100,32'h12345678,1,0,0,1,1,0,0,0, C_REQ|C_WR|C_STL,0,32'h100));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0,0,0,0, C_DN|C_WE,1,0));
        // SC with WB forwarding 0 over committed 1: fails without bus
        tbl.push_back(mk(1,1,32'h100,32'h5,1,1,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0,0,0,0, C_DN,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
        // SC with WB forwarding 1 over committed 0; bus holds off addr_ok one cycle
        tbl.push_back(mk(1,1,32'h100,32'hA5A5,0,1,1,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,32'h100,32'hA5A5,0,0,0,0,0,0,0,0, C_REQ|C_WR|C_STL,0,32'h100));
        tbl.push_back(mk(1,1,32'h100,32'hA5A5,0,0,0,1,0,0,0,0, C_REQ|C_WR|C_STL,0,32'h100));
        tbl.push_back(mk(1,1,32'h100,32'hA5A5,0,0,0,0,1,0,0,0, C_STL,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, C_DN|C_WE,1,0));
        // misaligned LL and SC
        tbl.push_back(mk(1,0,32'h102,0,0,0,0,0,0,0,0,0, C_ADEL,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,1,32'h101,0,1,0,0,0,0,0,0,0, C_ADES,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
        // next op presented during DONE stalls, then is accepted
        tbl.push_back(mk(1,0,32'h104,0,0,0,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,32'h104,0,0,0,0,1,1,32'hCAFEF00D,0,0, C_REQ|C_STL,0,32'h104));
        tbl.push_back(mk(1,0,32'h108,0,0,0,0,0,0,0,0,0, C_STL|C_DN|C_WE|C_VAL,32'hCAFEF00D,0));
        tbl.push_back(mk(1,0,32'h108,0,0,0,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,32'h108,0,0,0,0,1,1,32'h1,0,0, C_REQ|C_STL,0,32'h108));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, C_DN|C_WE|C_VAL,32'h1,0));
        // flush while in DONE suppresses the result
        tbl.push_back(mk(1,0,32'h10C,0,0,0,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,32'h10C,0,0,0,0,1,1,32'h5,0,0, C_REQ|C_STL,0,32'h10C));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
        // flush in IDLE alongside op_valid: op ignored, no exception either
        tbl.push_back(mk(1,0,32'h110,0,0,0,0,0,0,0,1,0, 0,0,0));
        tbl.push_back(mk(1,0,32'h112,0,0,0,0,0,0,0,1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,0, 0,0,0));
        // flush in REQ withdraws the request
        tbl.push_back(mk(1,0,32'h114,0,0,0,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,32'h114,0,0,0,0,0,0,0,1,0, C_STL,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset/ctl", {24'h0, data_req, data_wr, stall_req, done, llbit_we_o,
                            llbit_val_o, exc_adel, exc_ades}, 32'h0);
        check("reset/result", result, 32'h0);
        check("reset/addr", data_addr, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Exception flush in WAIT: drain, discard late data_ok, then accept again
        run_vec(mk(1,0,32'h300,0,0,0,0,0,0,0,0,0, 0,0,0), "drain_acc");
        run_vec(mk(1,0,32'h300,0,0,0,0,1,0,0,0,0, C_REQ|C_STL,0,32'h300), "drain_req");
        run_vec(mk(1,0,32'h300,0,0,0,0,0,0,0,1,1, C_STL,0,0), "drain_flush");
        run_vec(mk(1,0,32'h304,0,0,0,0,0,0,0,0,0, C_STL,0,0), "drain_hold1");
        run_vec(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0), "drain_hold2");
        run_vec(mk(1,0,32'h304,0,0,0,0,0,1,32'hBAD,0,0, C_STL,0,0), "drain_dok");
        run_vec(mk(1,0,32'h304,0,0,0,0,0,0,0,0,0, 0,0,0), "drain_next_acc");
        run_vec(mk(1,0,32'h304,0,0,0,0,1,1,32'h600D,0,0, C_REQ|C_STL,0,32'h304), "drain_next_req");
        run_vec(mk(0,0,0,0,0,0,0,0,0,0,0,0, C_DN|C_WE|C_VAL,32'h600D,0), "drain_next_done");

        // Reset in the middle of an access returns straight to IDLE
        run_vec(mk(1,0,32'h400,0,0,0,0,0,0,0,0,0, 0,0,0), "rst_acc");
        run_vec(mk(1,0,32'h400,0,0,0,0,1,0,0,0,0, C_REQ|C_STL,0,32'h400), "rst_req");
        @(negedge clk);
        rst = 1'b1;
        run_vec(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0), "rst_idle");
        rst = 1'b0;
        run_vec(mk(1,0,32'h404,0,0,0,0,0,0,0,0,0, 0,0,0), "rst_next_acc");
        run_vec(mk(1,0,32'h404,0,0,0,0,1,1,32'h77,0,0, C_REQ|C_STL,0,32'h404), "rst_next_req");
        run_vec(mk(0,0,0,0,0,0,0,0,0,0,0,0, C_DN|C_WE|C_VAL,32'h77,0), "rst_next_done");

`ifdef LLSC_ADDR_MATCH_EN
        run_vec(mk(1,0,32'h200,0,0,0,0,0,0,0,0,0, 0,0,0), "lm_ll_acc");
        run_vec(mk(1,0,32'h200,0,0,0,0,1,1,32'h11,0,0, C_REQ|C_STL,0,32'h200), "lm_ll_req");
        run_vec(mk(0,0,0,0,1,0,0,0,0,0,0,0, C_DN|C_WE|C_VAL,32'h11,0), "lm_ll_done");
        run_vec(mk(1,1,32'h204,32'h99,1,0,0,0,0,0,0,0, 0,0,0), "lm_sc_miss_acc");
        run_vec(mk(0,0,0,0,1,0,0,0,0,0,0,0, C_DN,0,0), "lm_sc_miss_done");
        run_vec(mk(1,1,32'h200,32'h99,1,0,0,0,0,0,0,0, 0,0,0), "lm_sc_hit_acc");
        run_vec(mk(1,1,32'h200,32'h99,1,0,0,1,1,0,0,0, C_REQ|C_WR|C_STL,0,32'h200), "lm_sc_hit_req");
        run_vec(mk(0,0,0,0,1,0,0,0,0,0,0,0, C_DN|C_WE,1,0), "lm_sc_hit_done");
        run_vec(mk(0,0,0,0,1,0,0,0,0,0,1,1, 0,0,0), "lm_exc_flush");
        run_vec(mk(1,1,32'h200,32'h99,1,0,0,0,0,0,0,0, 0,0,0), "lm_sc_clr_acc");
        run_vec(mk(0,0,0,0,1,0,0,0,0,0,0,0, C_DN,0,0), "lm_sc_clr_done");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
